// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable counter: counting-mode encoding.
package prog_counter_pkg;

    typedef logic [1:0] mode_t;

    // Behaviour on reaching the terminal value; encoding 3 is reserved and acts as WRAP.
    localparam mode_t MODE_WRAP    = 2'd0;
    localparam mode_t MODE_SAT     = 2'd1;
    localparam mode_t MODE_ONESHOT = 2'd2;

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits one tick every div+1 enabled cycles.
// The divide field is compared with >= so that lowering div below the
// current phase fires on the next enabled cycle instead of running
// the phase counter all the way round.
module counter_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] pre;

    assign tick = en & (pre >= div);

    // Phase counter: cleared by reset or load, frozen while en is low, restarts on tick.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre <= '0;
        end else if (en) begin
            if (tick) begin
                pre <= '0;
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Parametrised up/down counter with programmable terminal value,
// wrap/saturate/one-shot modes, prescaled enable, registered terminal-count
// pulse and a gated output for a shared bus.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_e,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  mode_t            mode,
    input  logic [PRE_W-1:0] div,
    input  logic             out_e,
    output logic [WIDTH-1:0] out_data,
    output logic             tc,
    output logic             done
);

    logic             tick;
    logic             terminal;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             done_d;

    counter_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load_e),
        .div  (div),
        .tick (tick)
    );

    // Up counts terminate at or beyond limit, so a load above limit ends on the next tick.
    assign terminal = dir ? (count >= limit) : (count == '0);

    // Next-state: load beats tick; a finished one-shot ignores ticks; tc pulses only on a terminal tick.
    always_comb begin
        count_d = count;
        tc_d    = 1'b0;
        done_d  = done;
        if (load_e) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (tick) begin
            if (mode == MODE_ONESHOT && done) begin
                count_d = count;
            end else if (terminal) begin
                tc_d = 1'b1;
                case (mode)
                    MODE_SAT:     count_d = count;
                    MODE_ONESHOT: done_d  = 1'b1;
                    default:      count_d = dir ? '0 : limit;
                endcase
            end else begin
                count_d = dir ? count + WIDTH'(1) : count - WIDTH'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            count <= count_d;
            tc    <= tc_d;
            done  <= done_d;
        end
    end

    assign out_data = out_e ? count : '0;

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: 8-bit instance for the main behaviour,
// 16-bit instance for the full-range wrap.
module tb_prog_counter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load_e;
    logic [7:0]  load_val;
    logic [7:0]  limit;
    logic        dir;
    logic [1:0]  mode;
    logic [3:0]  div;
    logic        out_e;
    logic [7:0]  out_data;
    logic        tc;
    logic        done;

    logic        en16;
    logic        load_e16;
    logic [15:0] load_val16;
    logic [15:0] out_data16;
    logic        tc16;
    logic        done16;

    int checks;
    int failures;

    prog_counter #(.WIDTH(8), .PRE_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .load_e(load_e), .load_val(load_val),
        .limit(limit), .dir(dir), .mode(mode), .div(div), .out_e(out_e),
        .out_data(out_data), .tc(tc), .done(done)
    );

    prog_counter #(.WIDTH(16), .PRE_W(4)) dut16 (
        .clk(clk), .rst(rst), .en(en16), .load_e(load_e16), .load_val(load_val16),
        .limit(16'hFFFF), .dir(1'b1), .mode(2'd0), .div(4'd0), .out_e(1'b1),
        .out_data(out_data16), .tc(tc16), .done(done16)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ct(input string tag, input logic [7:0] exp_count, input logic exp_tc);
        check({tag, ".count"}, 32'(out_data), 32'(exp_count));
        check({tag, ".tc"}, 32'(tc), 32'(exp_tc));
    endtask

    task automatic do_load(input logic [7:0] v);
        load_e   = 1'b1;
        load_val = v;
        cyc(1);
        load_e   = 1'b0;
    endtask

    initial begin
        logic [7:0] up_exp[6];
        logic       up_tc[6];
        logic [7:0] dn_exp[4];
        logic       dn_tc[4];
        up_exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
        up_tc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dn_exp = '{8'd1, 8'd0, 8'd9, 8'd8};
        dn_tc  = '{1'b0, 1'b0, 1'b1, 1'b0};
        checks = 0;
        failures = 0;

        rst = 1'b1; en = 1'b0; load_e = 1'b0; load_val = '0; limit = 8'd5;
        dir = 1'b1; mode = 2'd0; div = 4'd0; out_e = 1'b1;
        en16 = 1'b0; load_e16 = 1'b0; load_val16 = '0;
        cyc(2);
        chk_ct("reset", 8'd0, 1'b0);
        check("reset.done", 32'(done), 32'd0);

        // Basic up/wrap count from reset
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk_ct($sformatf("up%0d", i), up_exp[i], up_tc[i]);
        end

        // Down wrap to limit
        dir = 1'b0; limit = 8'd9;
        do_load(8'd2);
        chk_ct("dn_load", 8'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk_ct($sformatf("dn%0d", i), dn_exp[i], dn_tc[i]);
        end

        // Prescaler div=3 and en gap
        dir = 1'b1; limit = 8'd100; div = 4'd3;
        do_load(8'd0);
        cyc(3);
        chk_ct("pre_wait", 8'd0, 1'b0);
        cyc(1);
        chk_ct("pre_tick1", 8'd1, 1'b0);
        cyc(2);
        en = 1'b0;
        cyc(2);
        chk_ct("pre_hold", 8'd1, 1'b0);
        en = 1'b1;
        cyc(1);
        chk_ct("pre_stretch", 8'd1, 1'b0);
        cyc(1);
        chk_ct("pre_tick2", 8'd2, 1'b0);
        cyc(2);
        div = 4'd1;
        cyc(1);
        chk_ct("pre_lower_div", 8'd3, 1'b0);
        div = 4'd0;

        // SAT, limit=3
        mode = 2'd1; limit = 8'd3;
        do_load(8'd1);
        cyc(1); chk_ct("sat_a", 8'd2, 1'b0);
        cyc(1); chk_ct("sat_b", 8'd3, 1'b0);
        cyc(1); chk_ct("sat_c", 8'd3, 1'b1);
        cyc(1); chk_ct("sat_d", 8'd3, 1'b1);

        // ONESHOT, limit=3
        mode = 2'd2;
        do_load(8'd2);
        chk_ct("os_load", 8'd2, 1'b0);
        cyc(1); chk_ct("os_a", 8'd3, 1'b0);
        check("os_a.done", 32'(done), 32'd0);
        cyc(1); chk_ct("os_b", 8'd3, 1'b1);
        check("os_b.done", 32'(done), 32'd1);
        cyc(2); chk_ct("os_c", 8'd3, 1'b0);
        check("os_c.done", 32'(done), 32'd1);
        do_load(8'd0);
        chk_ct("os_reload", 8'd0, 1'b0);
        check("os_reload.done", 32'(done), 32'd0);
        cyc(1); chk_ct("os_resume", 8'd1, 1'b0);

        // Reserved mode acts as WRAP
        mode = 2'd3; limit = 8'd2;
        do_load(8'd2);
        cyc(1); chk_ct("rsvd_wrap", 8'd0, 1'b1);

        // Priority: load over tick, load with en low, rst over load
        mode = 2'd0; limit = 8'd50;
        do_load(8'd7);
        chk_ct("load_vs_tick", 8'd7, 1'b0);
        en = 1'b0;
        do_load(8'd9);
        chk_ct("load_en_low", 8'd9, 1'b0);
        en = 1'b1;
        rst = 1'b1; load_e = 1'b1; load_val = 8'd33;
        cyc(1);
        rst = 1'b0; load_e = 1'b0;
        chk_ct("rst_vs_load", 8'd0, 1'b0);

        // Output gating while counting
        out_e = 1'b0;
        cyc(3);
        check("oe_gate", 32'(out_data), 32'd0);
        out_e = 1'b1;
        #1;
        check("oe_count", 32'(out_data), 32'd3);

        // limit=0 up: every tick terminal
        limit = 8'd0;
        do_load(8'd0);
        cyc(1); chk_ct("lim0_a", 8'd0, 1'b1);
        cyc(1); chk_ct("lim0_b", 8'd0, 1'b1);

        // Load above limit: next tick wraps
        limit = 8'd100;
        do_load(8'd200);
        chk_ct("over_load", 8'd200, 1'b0);
        cyc(1); chk_ct("over_wrap", 8'd0, 1'b1);

        // 16-bit full-range wrap
        en16 = 1'b1; load_e16 = 1'b1; load_val16 = 16'hFFFD;
        cyc(1);
        load_e16 = 1'b0;
        check("w16_load", 32'(out_data16), 32'hFFFD);
        cyc(1); check("w16_a", 32'(out_data16), 32'hFFFE);
        cyc(1); check("w16_b", 32'(out_data16), 32'hFFFF);
        check("w16_b.tc", 32'(tc16), 32'd0);
        cyc(1); check("w16_c", 32'(out_data16), 32'h0000);
        check("w16_c.tc", 32'(tc16), 32'd1);
        cyc(1); check("w16_d", 32'(out_data16), 32'h0001);
        check("w16_done", 32'(done16), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
